// File: rtl/page_table_walker_if.sv
// Walker-facing bundle: MMU miss handshake, PTE memory port and tag RAM refill port.
// The walker connects through the slave modport; its environment connects through master.
interface page_table_walker_if #(
  parameter int TAG_RAM_ADDR_WIDTH = 6,
  parameter int TAG_WIDTH          = 20,
  parameter int PAYLOAD_WIDTH      = 32
);
  logic                          miss_valid;
  logic                          miss_ready;
  logic [TAG_WIDTH-1:0]          miss_vpn;
  logic [TAG_WIDTH-1:0]          satp_ppn;
  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic [31:0]                   mem_req_addr;
  logic                          mem_resp_valid;
  logic [31:0]                   mem_resp_data;
  logic                          refill_valid;
  logic                          refill_we;
  logic [TAG_RAM_ADDR_WIDTH-1:0] refill_idx;
  logic [TAG_WIDTH-1:0]          refill_tag;
  logic [PAYLOAD_WIDTH-1:0]      refill_payload;
  logic                          done_valid;
  logic                          done_fault;

  modport slave (
    input  miss_valid, miss_vpn, satp_ppn, mem_req_ready, mem_resp_valid, mem_resp_data,
    output miss_ready, mem_req_valid, mem_req_addr, refill_valid, refill_we, refill_idx,
           refill_tag, refill_payload, done_valid, done_fault
  );

  modport master (
    output miss_valid, miss_vpn, satp_ppn, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  miss_ready, mem_req_valid, mem_req_addr, refill_valid, refill_we, refill_idx,
           refill_tag, refill_payload, done_valid, done_fault
  );
endinterface

// File: rtl/page_table_walker.sv
// Two-level page-table walker: fetches L1/L0 PTEs over a single-outstanding port
// and either refills the TLB tag RAM or reports a page fault / timeout.
module page_table_walker #(
  parameter int TAG_RAM_ADDR_WIDTH = 6,
  parameter int TAG_WIDTH          = 20,
  parameter int PAYLOAD_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic               clk,
  input  logic               reset,
  page_table_walker_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_WAIT = 3'd2,
    L0_REQ  = 3'd3,
    L0_WAIT = 3'd4,
    REFILL  = 3'd5,
    FAULT   = 3'd6
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t               state_r, state_next_s;
  logic [TAG_WIDTH-1:0] vpn_r, vpn_next_s;
  logic [TAG_WIDTH-1:0] satp_r, satp_next_s;
  logic [TAG_WIDTH-1:0] final_ppn_r, final_ppn_next_s;
  logic [31:0]          pte_r, pte_next_s;
  logic [7:0]           timer_r, timer_next_s;

  // Invalid PTE, or the reserved write-without-read encoding.
  function automatic logic pte_bad(input logic [31:0] pte);
    return (pte[0] == 1'b0) || ((pte[2] == 1'b1) && (pte[1] == 1'b0));
  endfunction

  function automatic logic pte_leaf(input logic [31:0] pte);
    return (pte[1] == 1'b1) || (pte[3] == 1'b1);
  endfunction

  // Next-state and walk-context update.
  always_comb begin
    state_next_s     = state_r;
    vpn_next_s       = vpn_r;
    satp_next_s      = satp_r;
    final_ppn_next_s = final_ppn_r;
    pte_next_s       = pte_r;
    timer_next_s     = timer_r;
    case (state_r)
      IDLE: begin
        if (bus.miss_valid && bus.miss_ready) begin
          vpn_next_s   = bus.miss_vpn;
          satp_next_s  = bus.satp_ppn;
          state_next_s = L1_REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      L1_REQ, L0_REQ: begin
        if (bus.mem_req_ready) begin
          timer_next_s = 8'd0;
          state_next_s = (state_r == L1_REQ) ? L1_WAIT : L0_WAIT;
        end else begin
          state_next_s = state_r;
        end
      end
      L1_WAIT: begin
        if (bus.mem_resp_valid) begin
          pte_next_s = bus.mem_resp_data;
          if (pte_bad(bus.mem_resp_data)) begin
            state_next_s = FAULT;
          end else if (pte_leaf(bus.mem_resp_data)) begin
            // Superpage: the low 10 PPN bits must be zero; they are replaced by vpn0.
            if (bus.mem_resp_data[21:12] != 10'd0) begin
              state_next_s = FAULT;
            end else begin
              final_ppn_next_s = {bus.mem_resp_data[31:22], vpn_r[9:0]};
              state_next_s     = REFILL;
            end
          end else begin
            state_next_s = L0_REQ;
          end
        end else if (timer_r == TIMEOUT_LAST) begin
          state_next_s = FAULT;
        end else begin
          timer_next_s = timer_r + 8'd1;
        end
      end
      L0_WAIT: begin
        if (bus.mem_resp_valid) begin
          pte_next_s = bus.mem_resp_data;
          if (pte_bad(bus.mem_resp_data) || !pte_leaf(bus.mem_resp_data)) begin
            state_next_s = FAULT;
          end else begin
            final_ppn_next_s = bus.mem_resp_data[31:12];
            state_next_s     = REFILL;
          end
        end else if (timer_r == TIMEOUT_LAST) begin
          state_next_s = FAULT;
        end else begin
          timer_next_s = timer_r + 8'd1;
        end
      end
      REFILL:  state_next_s = IDLE;
      FAULT:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State and walk-context registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      timer_r     <= 8'd0;
      vpn_r       <= '0;
      satp_r      <= '0;
      final_ppn_r <= '0;
      pte_r       <= 32'd0;
    end else begin
      state_r     <= state_next_s;
      timer_r     <= timer_next_s;
      vpn_r       <= vpn_next_s;
      satp_r      <= satp_next_s;
      final_ppn_r <= final_ppn_next_s;
      pte_r       <= pte_next_s;
    end
  end

  // Outputs are registered from the next state so they are valid for the whole state.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.miss_ready     <= 1'b1;
      bus.mem_req_valid  <= 1'b0;
      bus.mem_req_addr   <= 32'd0;
      bus.refill_valid   <= 1'b0;
      bus.refill_we      <= 1'b0;
      bus.refill_idx     <= '0;
      bus.refill_tag     <= '0;
      bus.refill_payload <= '0;
      bus.done_valid     <= 1'b0;
      bus.done_fault     <= 1'b0;
    end else begin
      bus.miss_ready    <= (state_next_s == IDLE);
      bus.mem_req_valid <= (state_next_s == L1_REQ) || (state_next_s == L0_REQ);
      case (state_next_s)
        L1_REQ:  bus.mem_req_addr <= 32'({satp_next_s, vpn_next_s[TAG_WIDTH-1:10], 2'b00});
        L0_REQ:  bus.mem_req_addr <= 32'({pte_next_s[31:12], vpn_next_s[9:0], 2'b00});
        default: bus.mem_req_addr <= 32'd0;
      endcase
      bus.refill_valid   <= (state_next_s == REFILL);
      bus.refill_we      <= (state_next_s == REFILL);
      bus.refill_idx     <= (state_next_s == REFILL) ? vpn_next_s[TAG_RAM_ADDR_WIDTH-1:0] : '0;
      bus.refill_tag     <= (state_next_s == REFILL) ? vpn_next_s : '0;
      bus.refill_payload <= (state_next_s == REFILL) ?
                            PAYLOAD_WIDTH'({final_ppn_next_s, 8'h00, pte_next_s[3:0]}) : '0;
      bus.done_valid     <= (state_next_s == REFILL) || (state_next_s == FAULT);
      bus.done_fault     <= (state_next_s == FAULT);
    end
  end

endmodule

// File: tb/tb_page_table_walker.sv
// Self-checking bench for page_table_walker: directed scenarios plus randomized walks
// compared against an arithmetic reference model of the page-table rules.
module tb_page_table_walker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  page_table_walker_if ifc ();

  page_table_walker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [logic [31:0]];

  // Observations of the last walk
  logic [31:0] o_addr[$];
  int          o_we, o_done, o_refill_n, o_done_n, o_hs_n;
  logic        o_fault;
  logic [5:0]  o_idx;
  logic [19:0] o_tag;
  logic [31:0] o_payload;
  bit          o_unstable, o_busy_bad, o_aborted;

  // Reference model results
  bit          e_fault;
  int          e_nreq;
  logic [31:0] e_addr1, e_addr2, e_payload;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    else return 32'h0;
  endfunction

  function automatic void model_walk(input logic [19:0] satp, input logic [19:0] vpn, input bit no_resp);
    logic [31:0] p1, p2;
    int vpn1, vpn0;
    vpn1 = int'(vpn) / 1024;
    vpn0 = int'(vpn) % 1024;
    e_nreq = 1; e_fault = 1'b1; e_addr2 = 32'h0; e_payload = 32'h0;
    e_addr1 = satp * 4096 + vpn1 * 4;
    if (no_resp) return;
    p1 = mem_rd(e_addr1);
    if (p1[0] == 1'b0 || (p1[2] == 1'b1 && p1[1] == 1'b0)) return;
    if (p1[1] == 1'b1 || p1[3] == 1'b1) begin
      if (((p1 >> 12) % 1024) != 0) return;
      e_fault   = 1'b0;
      e_payload = ((p1 >> 22) * 1024 + vpn0) * 4096 + (p1 % 16);
      return;
    end
    e_nreq  = 2;
    e_addr2 = (p1 >> 12) * 4096 + vpn0 * 4;
    p2 = mem_rd(e_addr2);
    if (p2[0] == 1'b0 || (p2[2] == 1'b1 && p2[1] == 1'b0) || (p2[1] == 1'b0 && p2[3] == 1'b0)) return;
    e_fault   = 1'b0;
    e_payload = (p2 >> 12) * 4096 + (p2 % 16);
  endfunction

  // Issue one miss and act as the PTE memory until done (or an abort by reset in L0_WAIT).
  task automatic do_walk(input logic [19:0] satp, input logic [19:0] vpn, input int stall,
                         input int delay, input bit no_resp, input bit abort_l0);
    bit ready_drv = 1'b0;
    bit valid_prev = 1'b0;
    bit in_req = 1'b0;
    bit hs;
    int stall_left = 0;
    int resp_cnt = 0;
    int hs_count = 0;
    logic [31:0] hs_addr = 32'h0;
    o_addr.delete();
    o_we = 0; o_done = 0; o_refill_n = -1; o_done_n = -1; o_hs_n = -1; o_fault = 1'b0;
    o_idx = '0; o_tag = '0; o_payload = '0; o_unstable = 1'b0; o_busy_bad = 1'b0; o_aborted = 1'b0;
    @(negedge clk);
    check("miss_ready_idle", ifc.miss_ready, 1);
    ifc.miss_valid = 1'b1; ifc.miss_vpn = vpn; ifc.satp_ppn = satp;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (n == 1) begin
        ifc.miss_valid = 1'b0;
        ifc.miss_vpn   = 20'($urandom);
        ifc.satp_ppn   = 20'($urandom);
        if (ifc.miss_ready !== 1'b0) o_busy_bad = 1'b1;
      end
      hs = ready_drv && valid_prev;
      if (hs) begin
        hs_count++;
        o_hs_n  = n - 1;
        in_req  = 1'b0;
        hs_addr = o_addr[$];
        if (!no_resp) resp_cnt = delay;
      end
      if (abort_l0 && hs && hs_count == 2) begin
        reset = 1'b1;
        ifc.mem_resp_valid = 1'b0;
        ifc.mem_req_ready  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        o_aborted = 1'b1;
        break;
      end
      ifc.mem_resp_valid = 1'b0;
      ifc.mem_resp_data  = $urandom;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          ifc.mem_resp_valid = 1'b1;
          ifc.mem_resp_data  = mem_rd(hs_addr);
        end
      end
      if (ifc.mem_req_valid) begin
        if (!in_req) begin
          o_addr.push_back(ifc.mem_req_addr);
          in_req = 1'b1;
          stall_left = stall;
        end else if (ifc.mem_req_addr !== o_addr[$]) begin
          o_unstable = 1'b1;
        end
        ifc.mem_req_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        if (in_req) o_unstable = 1'b1;
        ifc.mem_req_ready = 1'($urandom_range(0, 1));
      end
      ready_drv  = ifc.mem_req_ready;
      valid_prev = ifc.mem_req_valid;
      if (ifc.refill_valid) begin
        o_refill_n = n; o_idx = ifc.refill_idx; o_tag = ifc.refill_tag; o_payload = ifc.refill_payload;
      end
      if (ifc.refill_we) o_we++;
      if (ifc.done_valid) begin
        o_done++; o_fault = ifc.done_fault; o_done_n = n;
        ifc.mem_resp_valid = 1'b0; ifc.mem_req_ready = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_walk(input string tag, input logic [19:0] satp, input logic [19:0] vpn, input bit no_resp);
    model_walk(satp, vpn, no_resp);
    check({tag, "_done"}, o_done, 1);
    check({tag, "_fault"}, o_fault, e_fault);
    check({tag, "_nreq"}, o_addr.size(), e_nreq);
    if (o_addr.size() > 0) check({tag, "_addr1"}, o_addr[0], e_addr1);
    if (e_nreq == 2 && o_addr.size() > 1) check({tag, "_addr2"}, o_addr[1], e_addr2);
    check({tag, "_we_count"}, o_we, e_fault ? 0 : 1);
    if (!e_fault) begin
      check({tag, "_payload"}, o_payload, e_payload);
      check({tag, "_idx"}, o_idx, vpn % 64);
      check({tag, "_tag"}, o_tag, vpn);
    end
    check({tag, "_req_stable"}, o_unstable, 0);
    check({tag, "_busy_ready"}, o_busy_bad, 0);
  endtask

  // Watch a few cycles in which nothing may complete.
  task automatic quiet_window(input string tag);
    int cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifc.mem_resp_valid = 1'b0;
      if (ifc.refill_valid || ifc.refill_we || ifc.done_valid) cnt++;
    end
    check({tag, "_no_activity"}, cnt, 0);
    check({tag, "_miss_ready"}, ifc.miss_ready, 1);
  endtask

  function automatic logic [31:0] rand_pte(input int kind);
    logic [19:0] ppn;
    logic [3:0]  fl;
    ppn = 20'($urandom);
    fl  = 4'($urandom);
    case (kind)
      0: fl[0] = 1'b0;                                       // invalid
      1: fl = {fl[3], 1'b1, 1'b0, 1'b1};                     // W without R
      2: begin ppn[9:0] = 10'd0; fl = {fl[3], fl[2], 1'b1, 1'b1}; end  // aligned leaf
      3: begin ppn[9:0] = ppn[9:0] | 10'd1; fl = {fl[3], fl[2], 1'b1, 1'b1}; end // misaligned / L0 leaf
      default: fl = 4'b0001;                                 // pointer (R=W=X=0)
    endcase
    return {ppn, 8'($urandom), fl};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [19:0] satp, vpn;
    logic [31:0] p1, a1, a2;
    int k1, k2;
    ifc.miss_valid = 1'b0; ifc.miss_vpn = 20'h0; ifc.satp_ppn = 20'h0;
    ifc.mem_req_ready = 1'b0; ifc.mem_resp_valid = 1'b0; ifc.mem_resp_data = 32'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_miss_ready", ifc.miss_ready, 1);
    check("rst_mem_req_valid", ifc.mem_req_valid, 0);
    check("rst_mem_req_addr", ifc.mem_req_addr, 0);
    check("rst_refill", {ifc.refill_valid, ifc.refill_we}, 0);
    check("rst_payload", ifc.refill_payload, 0);
    check("rst_done", {ifc.done_valid, ifc.done_fault}, 0);
    reset = 1'b0;

    // 1: two-level walk
    mem.delete();
    mem[32'h00010004] = 32'h00020001;
    mem[32'h0002000C] = 32'h12345007;
    do_walk(20'h00010, 20'h00403, 0, 1, 1'b0, 1'b0);
    check_walk("t1", 20'h00010, 20'h00403, 1'b0);
    check("t1_payload_lit", o_payload, 32'h12345007);
    check("t1_latency", o_refill_n, 5);

    // 2: superpage
    mem[32'h00010004] = 32'h40000003;
    do_walk(20'h00010, 20'h00403, 0, 1, 1'b0, 1'b0);
    check_walk("t2", 20'h00010, 20'h00403, 1'b0);
    check("t2_payload_lit", o_payload, 32'h40003003);
    check("t2_latency", o_refill_n, 3);

    // 3: misaligned superpage
    mem[32'h00010004] = 32'h40001003;
    do_walk(20'h00010, 20'h00403, 0, 1, 1'b0, 1'b0);
    check_walk("t3", 20'h00010, 20'h00403, 1'b0);
    check("t3_fault_lit", o_fault, 1);

    // 4: invalid L0 PTE, then an immediate repeat of walk 1
    mem[32'h00010004] = 32'h00020001;
    mem[32'h0002000C] = 32'h12345000;
    do_walk(20'h00010, 20'h00403, 0, 1, 1'b0, 1'b0);
    check_walk("t4a", 20'h00010, 20'h00403, 1'b0);
    mem[32'h0002000C] = 32'h12345007;
    do_walk(20'h00010, 20'h00403, 0, 1, 1'b0, 1'b0);
    check_walk("t4b", 20'h00010, 20'h00403, 1'b0);
    check("t4b_payload_lit", o_payload, 32'h12345007);

    // 5: request stall then response timeout, late response ignored
    do_walk(20'h00010, 20'h00403, 5, 1, 1'b1, 1'b0);
    check_walk("t5", 20'h00010, 20'h00403, 1'b1);
    check("t5_handshake_cycle", o_hs_n, 6);
    check("t5_wait_cycles", o_done_n - o_hs_n - 1, 255);
    @(negedge clk);
    ifc.mem_resp_valid = 1'b1; ifc.mem_resp_data = 32'h12345007;
    quiet_window("t5_late");

    // 6: reset in L0_WAIT, stray response, then recovery
    do_walk(20'h00010, 20'h00403, 0, 1, 1'b0, 1'b1);
    check("t6_reached_l0_wait", o_aborted, 1);
    check("t6_miss_ready", ifc.miss_ready, 1);
    check("t6_req_dropped", ifc.mem_req_valid, 0);
    ifc.mem_resp_valid = 1'b1; ifc.mem_resp_data = 32'h12345007;
    quiet_window("t6_stray");
    do_walk(20'h00010, 20'h00403, 0, 1, 1'b0, 1'b0);
    check_walk("t6_recover", 20'h00010, 20'h00403, 1'b0);

    // Randomized walks
    for (int w = 0; w < 24; w++) begin
      mem.delete();
      satp = 20'($urandom);
      vpn  = 20'($urandom);
      k1 = $urandom_range(0, 5);
      p1 = rand_pte(k1);
      a1 = {satp, vpn[19:10], 2'b00};
      mem[a1] = p1;
      if (k1 >= 4) begin
        k2 = $urandom_range(0, 4);
        a2 = {p1[31:12], vpn[9:0], 2'b00};
        mem[a2] = (k2 == 2) ? rand_pte(3) : rand_pte(k2);
      end
      do_walk(satp, vpn, $urandom_range(0, 3), $urandom_range(1, 4), 1'b0, 1'b0);
      check_walk($sformatf("rnd%0d", w), satp, vpn, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
